// File: rtl/arduino_move_rx.sv
// arduino_move_rx: UART receiver and command decoder for the Arduino player-2 link.
// Bytes '1'..'7' become a pending column on player2_move (cleared by move_ack),
// 'S' pulses player2_start, anything else well-framed pulses cmd_err.
// Optional macro ARDUINO_RX_PARITY_EN switches the frame from 8N1 to 8E1.
module arduino_move_rx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    input  logic       move_ack,
    output logic [2:0] player2_move,
    output logic       player2_start,
    output logic       frame_err,
    output logic       cmd_err
);

    localparam int DIV    = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [7:0]        CMD_START = 8'h53;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef ARDUINO_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH,
        DECODE
    } state_t;

    state_t state, state_nxt;

    logic              sync_p0, sync_p1;
    logic              rx_s;
    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [TICK_W-1:0] tick_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_reg;

    logic restart_div, tick_clr, tick_inc, shift_en, bit_clr;
    logic frame_err_set, decode_en;
    logic tick_at_half, tick_at_full;
`ifdef ARDUINO_RX_PARITY_EN
    logic par_bad, par_chk, par_err;
`endif

    // ASCII '1'..'7'
    function automatic logic is_move(input logic [7:0] b);
        return (b >= 8'h31) && (b <= 8'h37);
    endfunction

    // Column number is the byte minus ASCII '0'; only the low three bits survive
    function automatic logic [2:0] move_col(input logic [7:0] b);
        logic [7:0] diff;
        diff = b - 8'h30;
        return diff[2:0];
    endfunction

    assign rx_s         = sync_p1;
    assign tick         = (div_cnt == DIV_LAST);
    assign tick_at_half = tick && (tick_cnt == HALF_LAST);
    assign tick_at_full = tick && (tick_cnt == FULL_LAST);
`ifdef ARDUINO_RX_PARITY_EN
    assign par_err      = ^{shift_reg, rx_s};
`endif

    // Two-flop synchronizer on the asynchronous serial line (idles high)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= rx_serial;
            sync_p1 <= sync_p0;
        end
    end

    // Receiver state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and per-cycle strobes for the counters and outputs
    always_comb begin
        state_nxt     = state;
        restart_div   = 1'b0;
        tick_clr      = 1'b0;
        tick_inc      = 1'b0;
        shift_en      = 1'b0;
        bit_clr       = 1'b0;
        frame_err_set = 1'b0;
        decode_en     = 1'b0;
`ifdef ARDUINO_RX_PARITY_EN
        par_chk       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt   = START;
                    restart_div = 1'b1;
                    tick_clr    = 1'b1;
                end
            end
            START: begin
                if (tick_at_half) begin
                    tick_clr  = 1'b1;
                    bit_clr   = 1'b1;
                    state_nxt = rx_s ? IDLE : DATA;
                end else if (tick) begin
                    tick_inc = 1'b1;
                end
            end
            DATA: begin
                if (tick_at_full) begin
                    tick_clr = 1'b1;
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
`ifdef ARDUINO_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end else if (tick) begin
                    tick_inc = 1'b1;
                end
            end
`ifdef ARDUINO_RX_PARITY_EN
            PARITY: begin
                if (tick_at_full) begin
                    tick_clr      = 1'b1;
                    par_chk       = 1'b1;
                    frame_err_set = par_err;
                    state_nxt     = STOP;
                end else if (tick) begin
                    tick_inc = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick_at_full) begin
                    tick_clr = 1'b1;
                    if (!rx_s) begin
                        frame_err_set = 1'b1;
                        state_nxt     = WAIT_HIGH;
`ifdef ARDUINO_RX_PARITY_EN
                    end else if (par_bad) begin
                        state_nxt = IDLE;
`endif
                    end else begin
                        state_nxt = DECODE;
                    end
                end else if (tick) begin
                    tick_inc = 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_nxt = IDLE;
            end
            DECODE: begin
                decode_en = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Baud tick divider, bit-time tick counter, bit counter and shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
`ifdef ARDUINO_RX_PARITY_EN
            par_bad   <= 1'b0;
`endif
        end else begin
            if (restart_div || tick) div_cnt <= '0;
            else                     div_cnt <= div_cnt + 1'b1;

            if (tick_clr)      tick_cnt <= '0;
            else if (tick_inc) tick_cnt <= tick_cnt + 1'b1;

            if (bit_clr)       bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 1'b1;

            if (shift_en) shift_reg <= {rx_s, shift_reg[7:1]};

`ifdef ARDUINO_RX_PARITY_EN
            if (bit_clr)      par_bad <= 1'b0;
            else if (par_chk) par_bad <= par_err;
`endif
        end
    end

    // Command decode and move handshake; a fresh move beats a same-cycle ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            player2_move  <= 3'd0;
            player2_start <= 1'b0;
            frame_err     <= 1'b0;
            cmd_err       <= 1'b0;
        end else begin
            player2_start <= decode_en && (shift_reg == CMD_START);
            cmd_err       <= decode_en && !is_move(shift_reg) && (shift_reg != CMD_START);
            frame_err     <= frame_err_set;
            if (decode_en && is_move(shift_reg)) player2_move <= move_col(shift_reg);
            else if (move_ack)                   player2_move <= 3'd0;
        end
    end

endmodule

// File: tb/tb_arduino_move_rx.sv
// Directed bench for arduino_move_rx. The clock rate is scaled so that the
// tick divider is 4 (64 clocks per bit) to keep runs short; the receiver's
// behaviour per bit is identical to the 50 MHz / 9600 baud build.
`timescale 1ns/1ps
module tb_arduino_move_rx;

    localparam int CLK_HZ     = 614_400;
    localparam int BAUD       = 9600;
    localparam int OVERSAMPLE = 16;
    localparam int BIT        = 64;
`ifdef ARDUINO_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Expected start-fall to output-update latency: stop-bit middle plus a few sync cycles
    localparam int LAT_MIN = (NB - 1) * BIT + BIT / 2;
    localparam int LAT_MAX = LAT_MIN + 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_serial = 1'b1;
    logic       move_ack = 1'b0;
    logic [2:0] player2_move;
    logic       player2_start;
    logic       frame_err;
    logic       cmd_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int cnt_start = 0;
    int cnt_ferr = 0;
    int cnt_cerr = 0;
    int chg_cyc = 0;
    int start_cyc = 0;
    int lat = 0;
    logic [2:0] prev_move = 3'd0;

    arduino_move_rx #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_serial(rx_serial),
        .move_ack(move_ack),
        .player2_move(player2_move),
        .player2_start(player2_start),
        .frame_err(frame_err),
        .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count high cycles of each pulse output and note when the move changes
    always @(negedge clk) begin
        if (player2_start === 1'b1) cnt_start <= cnt_start + 1;
        if (frame_err === 1'b1)     cnt_ferr  <= cnt_ferr + 1;
        if (cmd_err === 1'b1)       cnt_cerr  <= cnt_cerr + 1;
        if (player2_move !== prev_move) chg_cyc <= cyc;
        prev_move <= player2_move;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout, expected summary before time limit");
        $fatal(1, "bench stopped by watchdog");
    end

    function automatic logic frame_bit(input logic [7:0] d, input logic stop,
                                       input logic par_flip, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (k == NB - 1) return stop;
        return (^d) ^ par_flip;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic par_flip, input int ack_off);
        for (int c = 0; c < NB * BIT; c++) begin
            @(negedge clk);
            if (c == 0) start_cyc = cyc;
            rx_serial = frame_bit(d, stop, par_flip, c / BIT);
            if (ack_off >= 0) move_ack = (c == ack_off);
        end
        move_ack = 1'b0;
    endtask

    task automatic idle_bits(input int n);
        for (int c = 0; c < n * BIT; c++) begin
            @(negedge clk);
            rx_serial = 1'b1;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++; if (player2_move !== 3'd0) begin n_bad++; $display("FAIL reset_move: got %0d expected 0", player2_move); end
        n_cmp++; if (player2_start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b expected 0", player2_start); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_err: got %b expected 0", cmd_err); end
        rst = 1'b0;
        idle_bits(2);
    endtask

    task automatic test_move;
        int f0, c0, s0;
        logic [2:0] early;
        f0 = cnt_ferr; c0 = cnt_cerr; s0 = cnt_start;
        early = 3'd7;
        fork
            send_frame(8'h34, 1'b1, 1'b0, -1);
            begin
                repeat ((NB - 1) * BIT + 9) @(negedge clk);
                early = player2_move;
            end
        join
        idle_bits(2);
        n_cmp++; if (early !== 3'd0) begin n_bad++; $display("FAIL move_early: got %0d expected 0 at stop-bit start", early); end
        n_cmp++; if (player2_move !== 3'd4) begin n_bad++; $display("FAIL move_4: got %0d expected 4", player2_move); end
        lat = chg_cyc - start_cyc;
        n_cmp++; if (lat < LAT_MIN || lat > LAT_MAX) begin n_bad++; $display("FAIL move_latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX); end
        idle_bits(10);
        n_cmp++; if (player2_move !== 3'd4) begin n_bad++; $display("FAIL move_hold: got %0d expected 4", player2_move); end
        @(negedge clk); move_ack = 1'b1;
        @(negedge clk); move_ack = 1'b0;
        n_cmp++; if (player2_move !== 3'd0) begin n_bad++; $display("FAIL move_ack_clear: got %0d expected 0", player2_move); end
        n_cmp++; if (cnt_ferr != f0 || cnt_cerr != c0 || cnt_start != s0) begin
            n_bad++; $display("FAIL move_no_pulses: got ferr+%0d cerr+%0d start+%0d expected all +0", cnt_ferr - f0, cnt_cerr - c0, cnt_start - s0);
        end
    endtask

    task automatic test_start;
        int f0, c0, s0;
        f0 = cnt_ferr; c0 = cnt_cerr; s0 = cnt_start;
        send_frame(8'h53, 1'b1, 1'b0, -1);
        idle_bits(2);
        n_cmp++; if (cnt_start - s0 != 1) begin n_bad++; $display("FAIL start_pulse: got %0d high cycles expected 1", cnt_start - s0); end
        n_cmp++; if (player2_move !== 3'd0) begin n_bad++; $display("FAIL start_move: got %0d expected 0", player2_move); end
        n_cmp++; if (cnt_ferr != f0 || cnt_cerr != c0) begin
            n_bad++; $display("FAIL start_no_err: got ferr+%0d cerr+%0d expected +0", cnt_ferr - f0, cnt_cerr - c0);
        end
    endtask

    task automatic test_back_to_back;
        int l2;
        send_frame(8'h32, 1'b1, 1'b0, -1);
        idle_bits(2);
        n_cmp++; if (player2_move !== 3'd2) begin n_bad++; $display("FAIL b2b_move_2: got %0d expected 2", player2_move); end
        l2 = chg_cyc - start_cyc;
        // Ack lands exactly on the decode cycle of the next byte
        send_frame(8'h36, 1'b1, 1'b0, l2 - 1);
        n_cmp++; if (player2_move !== 3'd6) begin n_bad++; $display("FAIL b2b_move_6: got %0d expected 6", player2_move); end
        idle_bits(2);
        n_cmp++; if (player2_move !== 3'd6) begin n_bad++; $display("FAIL b2b_ack_on_decode: got %0d expected 6", player2_move); end
    endtask

    task automatic test_cmd_err;
        int f0, c0, s0;
        f0 = cnt_ferr; c0 = cnt_cerr; s0 = cnt_start;
        send_frame(8'h78, 1'b1, 1'b0, -1);
        idle_bits(2);
        n_cmp++; if (cnt_cerr - c0 != 1) begin n_bad++; $display("FAIL cmd_err_pulse: got %0d high cycles expected 1", cnt_cerr - c0); end
        n_cmp++; if (player2_move !== 3'd6) begin n_bad++; $display("FAIL cmd_err_move: got %0d expected 6", player2_move); end
        n_cmp++; if (cnt_ferr != f0 || cnt_start != s0) begin
            n_bad++; $display("FAIL cmd_err_other: got ferr+%0d start+%0d expected +0", cnt_ferr - f0, cnt_start - s0);
        end
    endtask

    task automatic test_glitch;
        int f0, c0, s0;
        f0 = cnt_ferr; c0 = cnt_cerr; s0 = cnt_start;
        for (int c = 0; c < 5 * (BIT / OVERSAMPLE); c++) begin
            @(negedge clk);
            rx_serial = 1'b0;
        end
        idle_bits(3);
        n_cmp++; if (cnt_ferr != f0 || cnt_cerr != c0 || cnt_start != s0) begin
            n_bad++; $display("FAIL glitch_pulses: got ferr+%0d cerr+%0d start+%0d expected all +0", cnt_ferr - f0, cnt_cerr - c0, cnt_start - s0);
        end
        n_cmp++; if (player2_move !== 3'd6) begin n_bad++; $display("FAIL glitch_move: got %0d expected 6", player2_move); end
    endtask

    task automatic test_frame_err;
        int f0, c0;
        f0 = cnt_ferr; c0 = cnt_cerr;
        send_frame(8'h31, 1'b0, 1'b0, -1);
        idle_bits(2);
        n_cmp++; if (cnt_ferr - f0 != 1) begin n_bad++; $display("FAIL frame_err_pulse: got %0d high cycles expected 1", cnt_ferr - f0); end
        n_cmp++; if (player2_move !== 3'd6) begin n_bad++; $display("FAIL frame_err_move: got %0d expected 6", player2_move); end
        n_cmp++; if (cnt_cerr != c0) begin n_bad++; $display("FAIL frame_err_cmd: got cerr+%0d expected +0", cnt_cerr - c0); end
        f0 = cnt_ferr;
        for (int c = 0; c < 30 * BIT; c++) begin
            @(negedge clk);
            rx_serial = 1'b0;
        end
        idle_bits(2);
        n_cmp++; if (cnt_ferr - f0 != 1) begin n_bad++; $display("FAIL stuck_low: got %0d frame_err cycles expected 1", cnt_ferr - f0); end
        f0 = cnt_ferr;
        send_frame(8'h35, 1'b1, 1'b0, -1);
        idle_bits(2);
        n_cmp++; if (player2_move !== 3'd5) begin n_bad++; $display("FAIL recover_move_5: got %0d expected 5", player2_move); end
        n_cmp++; if (cnt_ferr != f0) begin n_bad++; $display("FAIL recover_no_err: got ferr+%0d expected +0", cnt_ferr - f0); end
    endtask

    task automatic test_reset_mid;
        for (int c = 0; c < 5 * BIT + BIT / 2; c++) begin
            @(negedge clk);
            rx_serial = frame_bit(8'h37, 1'b1, 1'b0, c / BIT);
        end
        @(negedge clk);
        rst = 1'b1;
        rx_serial = 1'b1;
        @(negedge clk);
        n_cmp++; if (player2_move !== 3'd0) begin n_bad++; $display("FAIL rst_mid_move: got %0d expected 0", player2_move); end
        n_cmp++; if ({player2_start, frame_err, cmd_err} !== 3'b000) begin
            n_bad++; $display("FAIL rst_mid_pulses: got %b expected 000", {player2_start, frame_err, cmd_err});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_bits(12);
        n_cmp++; if (player2_move !== 3'd0) begin n_bad++; $display("FAIL rst_mid_no_move: got %0d expected 0", player2_move); end
        send_frame(8'h37, 1'b1, 1'b0, -1);
        idle_bits(2);
        n_cmp++; if (player2_move !== 3'd7) begin n_bad++; $display("FAIL rst_mid_move_7: got %0d expected 7", player2_move); end
    endtask

`ifdef ARDUINO_RX_PARITY_EN
    task automatic test_parity;
        int f0;
        @(negedge clk); move_ack = 1'b1;
        @(negedge clk); move_ack = 1'b0;
        send_frame(8'h33, 1'b1, 1'b0, -1);
        idle_bits(2);
        n_cmp++; if (player2_move !== 3'd3) begin n_bad++; $display("FAIL parity_good: got %0d expected 3", player2_move); end
        @(negedge clk); move_ack = 1'b1;
        @(negedge clk); move_ack = 1'b0;
        f0 = cnt_ferr;
        send_frame(8'h33, 1'b1, 1'b1, -1);
        idle_bits(2);
        n_cmp++; if (cnt_ferr - f0 != 1) begin n_bad++; $display("FAIL parity_bad_err: got %0d frame_err cycles expected 1", cnt_ferr - f0); end
        n_cmp++; if (player2_move !== 3'd0) begin n_bad++; $display("FAIL parity_bad_move: got %0d expected 0", player2_move); end
    endtask
`endif

    initial begin
        test_reset;
        test_move;
        test_start;
        test_back_to_back;
        test_cmd_err;
        test_glitch;
        test_frame_err;
        test_reset_mid;
`ifdef ARDUINO_RX_PARITY_EN
        test_parity;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
